// File: rtl/bcd_display_if.sv
// Value/strobe in, busy and multiplexed 7-segment drive out, for the bcd_display block.
interface bcd_display_if;
   logic [7:0] value;
   logic       load;
   logic       busy;
   logic [3:0] dig;
   logic [6:0] seg;

   modport master (output value, load, input busy, dig, seg);
   modport slave  (input value, load, output busy, dig, seg);
endinterface

// File: rtl/bcd_display.sv
// O-register display driver: sequential double-dabble to 3 BCD digits plus a 4-digit scan.
// Optional SIGNED_MODE_EN: treat value as two's complement and light a minus on the sign digit.
module bcd_display #(
   parameter int SCAN_DIV = 4
) (
   input  logic         clk,
   input  logic         reset,
   bcd_display_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   state_t      state, state_nxt;
   logic [7:0]  bin_q, pend_val;
   logic [11:0] bcd_q, bcd_adj;
   logic [19:0] dd_shift;
   logic [2:0]  cnt;
   logic        sign_q, pend;
   logic [3:0]  d_hun, d_ten, d_one;
   logic        d_sign;
   logic        start;
   logic [7:0]  start_val;
   logic [PW-1:0] presc;
   logic [1:0]  idx;
   logic        wrap;
   logic [3:0]  dig_q;
   logic [6:0]  seg_q, seg_nxt;

   // {sign, magnitude} of an incoming value
   function automatic logic [8:0] mag_sign(input logic [7:0] v);
`ifdef SIGNED_MODE_EN
      return v[7] ? {1'b1, ~v + 8'd1} : {1'b0, v};
`else
      return {1'b0, v};
`endif
   endfunction

   function automatic logic [11:0] dd_adj(input logic [11:0] b);
      logic [11:0] r;
      r = '0;
      for (int i = 0; i < 3; i++)
         r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
      return r;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   assign bcd_adj  = dd_adj(bcd_q);
   assign dd_shift = {bcd_adj, bin_q} << 1;

   // A load that lands in COMMIT with nothing pending is picked up from IDLE next cycle.
   assign start     = bus.load | pend;
   assign start_val = bus.load ? bus.value : pend_val;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = CONV;
         CONV:    if (cnt == 3'd7) state_nxt = COMMIT;
         COMMIT:  state_nxt = pend ? CONV : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         pend     <= 1'b0;
         pend_val <= '0;
         bin_q    <= '0;
         bcd_q    <= '0;
         cnt      <= '0;
         sign_q   <= 1'b0;
         d_hun    <= '0;
         d_ten    <= '0;
         d_one    <= '0;
         d_sign   <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (start) begin
               {sign_q, bin_q} <= mag_sign(start_val);
               bcd_q <= '0;
               cnt   <= '0;
            end
            CONV: begin
               bcd_q <= dd_shift[19:8];
               bin_q <= dd_shift[7:0];
               cnt   <= cnt + 3'd1;
            end
            COMMIT: begin
               d_hun  <= bcd_q[11:8];
               d_ten  <= bcd_q[7:4];
               d_one  <= bcd_q[3:0];
               d_sign <= sign_q;
               if (pend) begin
                  {sign_q, bin_q} <= mag_sign(pend_val);
                  bcd_q <= '0;
                  cnt   <= '0;
               end
            end
            default: ;
         endcase
         if (state == IDLE)
            pend <= 1'b0;
         else if (bus.load) begin
            pend     <= 1'b1;
            pend_val <= bus.value;
         end else if (state == COMMIT)
            pend <= 1'b0;
      end
   end

   assign bus.busy = (state != IDLE) | pend;

   // Scan runs free of the converter; leading zeros blanked on hundreds/tens.
   assign wrap = (presc == PW'(SCAN_DIV - 1));

   always_comb begin
      seg_nxt = 7'h00;
      case (idx)
         2'd0:    seg_nxt = seg7(d_one);
         2'd1:    if (d_hun != 4'd0 || d_ten != 4'd0) seg_nxt = seg7(d_ten);
         2'd2:    if (d_hun != 4'd0) seg_nxt = seg7(d_hun);
         default: if (d_sign) seg_nxt = 7'h40;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         presc <= '0;
         idx   <= '0;
         dig_q <= 4'b0001;
         seg_q <= 7'h3F;
      end else begin
         presc <= wrap ? '0 : presc + 1'b1;
         if (wrap) idx <= idx + 2'd1;
         dig_q <= 4'b0001 << idx;
         seg_q <= seg_nxt;
      end
   end

   assign bus.dig = dig_q;
   assign bus.seg = seg_q;
endmodule

// File: tb/tb_bcd_display.sv
// Scoreboard bench for bcd_display: expected display snapshots and busy-run lengths are queued
// at stimulus time and retired by a negedge monitor watching the scanned outputs.
module tb_bcd_display;
  typedef logic [3:0][6:0] snap_t;  // [3]=sign [2]=hundreds [1]=tens [0]=ones

  logic clk = 1'b0;
  logic reset = 1'b0;
  bcd_display_if ifc();

  bcd_display #(.SCAN_DIV(2)) dut (.clk(clk), .reset(reset), .bus(ifc));

  always #5 clk = ~clk;

  snap_t exp_q[$];
  int    run_q[$];
  snap_t cur = {7'h00, 7'h00, 7'h00, 7'h3F};
  logic [3:0] seen = '0;
  int pass_n = 0, fail_n = 0;
  int run = 0, scan_cnt = 0, didx;
  logic [3:0] ed;
  bit mon_en = 0, fin = 0, fin_done = 0;
  int e;

  task automatic chk(input string nm, input int got, input int exp);
    if (got == exp) pass_n++;
    else begin
      fail_n++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      // scan sequence straight out of reset
      if (scan_cnt < 9) begin
        ed = (scan_cnt == 0) ? 4'b0001 : 4'(1 << ((scan_cnt - 1) / 2));
        chk("scan_dig", int'(ifc.dig), int'(ed));
        chk("scan_seg", int'(ifc.seg), (ed == 4'b0001) ? 32'h3F : 32'h00);
        scan_cnt++;
      end
      // display scoreboard: each digit shows old or next snapshot, never anything else
      didx = -1;
      for (int k = 0; k < 4; k++) if (ifc.dig == 4'(1 << k)) didx = k;
      if (didx < 0) begin
        fail_n++;
        $display("FAIL dig_onehot: got %b expected one-hot", ifc.dig);
      end else if (exp_q.size() > 0 && ifc.seg == exp_q[0][didx]) begin
        seen[didx] = 1'b1;
        if (&seen) begin
          cur = exp_q.pop_front();
          seen = '0;
          pass_n++;
        end
      end else if (!seen[didx] && ifc.seg == cur[didx]) begin
      end else begin
        fail_n++;
        $display("FAIL disp digit %0d: got %h expected %h or %h", didx, ifc.seg, cur[didx],
                 (exp_q.size() > 0) ? exp_q[0][didx] : 7'h00);
      end
      // busy run-length scoreboard
      if (ifc.busy) run++;
      else if (run > 0) begin
        if (run_q.size() == 0) chk("busy_run_unexpected", run, 0);
        else begin
          e = run_q.pop_front();
          chk("busy_run", run, e);
        end
        run = 0;
      end
      if (fin && !fin_done) begin
        chk("disp_q_empty", exp_q.size(), 0);
        chk("run_q_empty", run_q.size(), 0);
        fin_done = 1;
      end
    end
  end

  task automatic push_disp(input logic [6:0] s, input logic [6:0] h, input logic [6:0] t,
                           input logic [6:0] o);
    exp_q.push_back({s, h, t, o});
  endtask

  task automatic do_load(input logic [7:0] v);
    @(posedge clk); #1;
    ifc.value = v;
    ifc.load = 1'b1;
    @(posedge clk); #1;
    ifc.load = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && run_q.size() == 0 && !ifc.busy) break;
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    ifc.value = '0;
    ifc.load = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    mon_en = 1;
    repeat (12) @(posedge clk);

    run_q.push_back(9); push_disp(7'h00, 7'h00, 7'h6F, 7'h7D); do_load(8'h60); wait_idle();
    run_q.push_back(9); push_disp(7'h00, 7'h5B, 7'h6D, 7'h6D); do_load(8'hFF); wait_idle();
    run_q.push_back(9); push_disp(7'h00, 7'h00, 7'h00, 7'h3F); do_load(8'h00); wait_idle();
`ifdef SIGNED_MODE_EN
    run_q.push_back(9); push_disp(7'h40, 7'h00, 7'h06, 7'h3F); do_load(8'hF6); wait_idle();
    run_q.push_back(9); push_disp(7'h40, 7'h06, 7'h5B, 7'h7F); do_load(8'h80); wait_idle();
`else
    run_q.push_back(9); push_disp(7'h00, 7'h5B, 7'h66, 7'h7D); do_load(8'hF6); wait_idle();
    run_q.push_back(9); push_disp(7'h00, 7'h06, 7'h5B, 7'h7F); do_load(8'h80); wait_idle();
`endif

    // 7, then 150 and 200 while busy: 200 overwrites 150
    run_q.push_back(18);
    push_disp(7'h00, 7'h00, 7'h00, 7'h07);
    push_disp(7'h00, 7'h5B, 7'h3F, 7'h3F);
    @(posedge clk); #1 ifc.value = 8'd7; ifc.load = 1'b1;
    @(posedge clk); #1 ifc.load = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 ifc.value = 8'd150; ifc.load = 1'b1;
    @(posedge clk); #1 ifc.value = 8'd200;
    @(posedge clk); #1 ifc.load = 1'b0;
    wait_idle();

    // 99 aborted by reset on the 4th CONV edge; a load in the reset cycle is ignored
    run_q.push_back(4);
    push_disp(7'h00, 7'h00, 7'h00, 7'h3F);
    do_load(8'd99);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; ifc.value = 8'd55; ifc.load = 1'b1;
    @(posedge clk); #1 reset = 1'b1; ifc.load = 1'b0;
    wait_idle();
    repeat (30) @(posedge clk);

    fin = 1;
    repeat (2) @(posedge clk);
    if (!fin_done) begin
      fail_n++;
      $display("FAIL final_check: got not-run expected run");
    end
    $display("%0d/%0d checks passed", pass_n, pass_n + fail_n);
    $finish;
  end
endmodule
